// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, IMEM write port, core hold and load status
interface imem_loader_if #(parameter int ADDR_WIDTH = 8, parameter int INST_WIDTH = 32);
  logic                  start;
  logic [ADDR_WIDTH:0]   num_words;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_wdata;
  logic                  core_hold;
  logic                  done;
  logic                  bad_opcode;
  logic [ADDR_WIDTH-1:0] err_addr;
  modport master (
    output start, num_words, byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata, core_hold, done, bad_opcode, err_addr
  );
  modport slave (
    input  start, num_words, byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata, core_hold, done, bad_opcode, err_addr
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words, writes them to IMEM
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   num_words_q, num_words_d;
  logic [INST_WIDTH-1:0] asm_q, asm_d;
  logic                  bad_q, bad_d;
  logic [ADDR_WIDTH-1:0] err_q, err_d;
  logic                  legal;
  assign legal = asm_q[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63, 7'h37, 7'h6F};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      asm_q       <= '0;
      bad_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      num_words_q <= num_words_d;
      asm_q       <= asm_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    num_words_d = num_words_q;
    asm_d       = asm_q;
    bad_d       = bad_q;
    err_d       = err_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        num_words_d = bus.num_words;
        state_d     = (bus.num_words == '0) ? DONE : COLLECT;
        if (bus.num_words != '0) begin
          word_cnt_d = '0;
          byte_cnt_d = '0;
          bad_d      = 1'b0;
          err_d      = '0;
        end
      end
      COLLECT: if (bus.byte_valid) begin
        asm_d[8*byte_cnt_q +: 8] = bus.byte_in;
        byte_cnt_d = byte_cnt_q + 2'd1;
        state_d    = (byte_cnt_q == 2'd3) ? WRITE : COLLECT;
      end
      WRITE: begin
        // only the first illegal word records its address
        if (!legal && !bad_q) begin
          bad_d = 1'b1;
          err_d = word_cnt_q[ADDR_WIDTH-1:0];
        end
        state_d    = (word_cnt_q + 1'b1 == num_words_q) ? DONE : COLLECT;
        word_cnt_d = (word_cnt_q + 1'b1 == num_words_q) ? word_cnt_q : word_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.byte_ready = state_q == COLLECT;
  assign bus.core_hold  = state_q == COLLECT || state_q == WRITE;
  assign bus.imem_we    = state_q == WRITE;
  assign bus.imem_addr  = word_cnt_q[ADDR_WIDTH-1:0];
  assign bus.imem_wdata = asm_q;
  assign bus.done       = state_q == DONE;
  assign bus.bad_opcode = bad_q;
  assign bus.err_addr   = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads checked against a word-level model of the loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int hold_cnt = 0;
  logic [39:0] exp_q[$];
  logic [39:0] e;
  logic [31:0] wq[$];
  logic [7:0]  bq[$];
  logic [31:0] wlog[$];
  logic [7:0]  alog[$];
  logic [6:0]  legal_ops[8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63, 7'h37, 7'h6F};

  imem_loader_if #(.ADDR_WIDTH(8), .INST_WIDTH(32)) bus ();
  imem_loader #(.ADDR_WIDTH(8), .INST_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(logic [31:0] w);
    foreach (legal_ops[i]) if (w[6:0] == legal_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (bus.core_hold === 1'b1) hold_cnt++;
    if (bus.imem_we !== 1'b0) begin
      alog.push_back(bus.imem_addr);
      wlog.push_back(bus.imem_wdata);
      chk("ready_low_in_write", {63'd0, bus.byte_ready}, 64'd0);
      chk("hold_in_write", {63'd0, bus.core_hold}, 64'd1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got write addr %0h data %0h, expected no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {56'd0, bus.imem_addr}, {56'd0, e[39:32]});
        chk("wr_data", {32'd0, bus.imem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic pulse_start(int n);
    bus.start = 1'b1;
    bus.num_words = 9'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: byte_ready stayed %b, expected 1", bus.byte_ready);
    end
    bus.byte_valid = 1'b1;
    bus.byte_in = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'hxx;
  endtask

  task automatic load(int gap, bit poke);
    int n = wq.size();
    int first_bad = -1;
    int t = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({i[7:0], wq[i]});
      if (first_bad < 0 && !is_legal(wq[i])) first_bad = i;
    end
    alog.delete();
    wlog.delete();
    @(negedge clk);
    hold_cnt = 0;
    pulse_start(n);
    if (poke) pulse_start(0);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) send_byte(wq[i][8*k +: 8], (k % 2 == 1) ? gap : 0);
    while (bus.done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("done", {63'd0, bus.done}, 64'd1);
    chk("hold_after_done", {63'd0, bus.core_hold}, 64'd0);
    chk("ready_after_done", {63'd0, bus.byte_ready}, 64'd0);
    chk("bad_opcode", {63'd0, bus.bad_opcode}, {63'd0, first_bad >= 0});
    chk("err_addr", {56'd0, bus.err_addr}, (first_bad >= 0) ? 64'(first_bad) : 64'd0);
    chk("writes_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_words = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, bus.byte_ready}, 64'd0);
    chk("rst_we", {63'd0, bus.imem_we}, 64'd0);
    chk("rst_addr", {56'd0, bus.imem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
    chk("rst_hold", {63'd0, bus.core_hold}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_bad", {63'd0, bus.bad_opcode}, 64'd0);
    chk("rst_err", {56'd0, bus.err_addr}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // zero-length load: done on the next cycle, no write
    pulse_start(0);
    chk("t4_done", {63'd0, bus.done}, 64'd1);
    chk("t4_hold", {63'd0, bus.core_hold}, 64'd0);
    repeat (3) @(negedge clk);
    chk("t4_no_write", 64'(wlog.size()), 64'd0);
    // two words from the literal byte stream, packed little-endian by the model
    bq = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h33, 8'h85, 8'ha5, 8'h00};
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back({bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]});
    load(0, 1'b0);
    chk("t1_hold_cycles", 64'(hold_cnt), 64'd10);
    chk("t1_nwrites", 64'(wlog.size()), 64'd2);
    chk("t1_w0", {32'd0, wlog[0]}, 64'h00500513);
    chk("t1_w1", {32'd0, wlog[1]}, 64'h00a58533);
    chk("t1_a1", {56'd0, alog[1]}, 64'd1);
    // same stream with valid gaps and a start pulse that must be ignored mid-load
    load(1, 1'b1);
    chk("t2_nwrites", 64'(wlog.size()), 64'd2);
    chk("t2_w0", {32'd0, wlog[0]}, 64'h00500513);
    chk("t2_w1", {32'd0, wlog[1]}, 64'h00a58533);
    // two illegal words: only the first one's address is kept
    wq = '{32'h00000013, 32'hFFFFFFFF, 32'h0000007F};
    load(0, 1'b0);
    chk("t3_nwrites", 64'(wlog.size()), 64'd3);
    chk("t3_bad", {63'd0, bus.bad_opcode}, 64'd1);
    chk("t3_err", {56'd0, bus.err_addr}, 64'd1);
    // reset in the middle of word 0, then reload a single word
    @(negedge clk);
    wlog.delete();
    pulse_start(1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_we", {63'd0, bus.imem_we}, 64'd0);
    chk("t5_rst_hold", {63'd0, bus.core_hold}, 64'd0);
    chk("t5_rst_bad", {63'd0, bus.bad_opcode}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t5_no_write", 64'(wlog.size()), 64'd0);
    wq = '{32'h00001037};
    load(0, 1'b0);
    chk("t5_a0", {56'd0, alog[0]}, 64'd0);
    chk("t5_w0", {32'd0, wlog[0]}, 64'h00001037);
    // full IMEM: 256 words, no wrap back to address 0
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(32'h00000013 | (32'(i) << 12));
    load(0, 1'b0);
    chk("t6_nwrites", 64'(wlog.size()), 64'd256);
    chk("t6_last_addr", {56'd0, alog[255]}, 64'd255);
    repeat (5) @(negedge clk);
    chk("t6_no_extra", 64'(wlog.size()), 64'd256);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
